// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter and sequencer for the shared 32-bit 8:1 mux.
// Drives a registered select and a one-hot grant, and handshakes each beat with the
// downstream consumer (out_valid/out_ready). Locked bursts are capped at MAX_BURST beats.
// Optional feature: define MUX_ARB_TIMEOUT_EN to add a stall watchdog. The watchdog
// releases a grant after TIMEOUT stalled cycles and pulses err.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] lock,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] beat,
  output logic       err
);

  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Elaboration-time range checks on the configuration
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("mux8_rr_arbiter: MAX_BURST must be in 1..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mux8_rr_arbiter: TIMEOUT must be in 1..255");
  end

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [SEL_W-1:0]   sel_d;
  logic [N_CH-1:0]    gnt_d;
  logic               busy_d;
  logic               err_d;
  logic [CNT_W:0]     bcnt_inc;
  logic               release_c;
  logic [SEL_W-1:0]   pick_c;
`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]   scnt_q, scnt_d;
`endif

  // First requesting channel scanning ptr, ptr+1, ... modulo 8
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_CH-1:0] r,
                                               input logic [SEL_W-1:0] p);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    logic             found;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      idx = p + SEL_W'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Handshake outputs: valid only while the granted channel still requests
  assign out_valid = busy & req[sel];
  assign beat      = (out_valid & out_ready) ? gnt : {N_CH{1'b0}};

  assign pick_c   = rr_pick(req, ptr_q);
  assign bcnt_inc = (CNT_W+1)'(bcnt_q) + (CNT_W+1)'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    bcnt_d    = bcnt_q;
    sel_d     = sel;
    gnt_d     = gnt;
    err_d     = 1'b0;
    release_c = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    scnt_d    = scnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (req != {N_CH{1'b0}}) begin
          state_d = BUSY;
          sel_d   = pick_c;
          gnt_d   = N_CH'(1) << pick_c;
          bcnt_d  = '0;
`ifdef MUX_ARB_TIMEOUT_EN
          scnt_d  = '0;
`endif
        end
      end
      BUSY: begin
        if (!req[sel]) begin
          // Withdrawn request: no beat, hand the path back
          release_c = 1'b1;
        end else if (out_ready) begin
          // Beat accepted; a held lock keeps the grant until the burst cap
          bcnt_d = bcnt_inc[CNT_W-1:0];
          if (lock[sel] && (bcnt_inc < (CNT_W+1)'(MAX_BURST))) begin
`ifdef MUX_ARB_TIMEOUT_EN
            scnt_d = '0;
`endif
          end else begin
            release_c = 1'b1;
          end
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
          // Stalled cycle: count toward the watchdog limit
          if (scnt_q == CNT_W'(TIMEOUT - 1)) begin
            release_c = 1'b1;
            err_d     = 1'b1;
          end else begin
            scnt_d = scnt_q + CNT_W'(1);
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    if (release_c) begin
      state_d = IDLE;
      gnt_d   = '0;
      ptr_d   = sel + SEL_W'(1);
    end

    busy_d = (state_d == BUSY);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      sel     <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      sel     <= sel_d;
      gnt     <= gnt_d;
      busy    <= busy_d;
      err     <= err_d;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Watchdog stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: per-cycle vector table plus reset and watchdog sequences.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] lock;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] beat;
  logic       err;

  int n_vec;
  int n_bad;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] lock;
    logic       rdy;
    logic [7:0] e_gnt;
    logic [2:0] e_sel;
    logic       e_busy;
    logic       e_valid;
    logic [7:0] e_beat;
  } vec_t;

  vec_t tbl[$];

  mux8_rr_arbiter #(.MAX_BURST(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .sel       (sel),
    .gnt       (gnt),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .beat      (beat),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] lk, input logic rd,
                     input logic [7:0] eg, input logic [2:0] es, input logic eb,
                     input logic ev, input logic [7:0] ebt);
    vec_t v;
    v.rst_n = r;  v.req = rq;  v.lock = lk;  v.rdy = rd;
    v.e_gnt = eg; v.e_sel = es; v.e_busy = eb; v.e_valid = ev; v.e_beat = ebt;
    tbl.push_back(v);
  endtask

  task automatic check_outs(input string name, input logic [7:0] eg, input logic [2:0] es,
                            input logic eb, input logic ev, input logic [7:0] ebt,
                            input logic ee);
    n_vec++;
    if (gnt !== eg || sel !== es || busy !== eb || out_valid !== ev || beat !== ebt || err !== ee) begin
      n_bad++;
      $display("FAIL %s: gnt=%h want %h sel=%0d want %0d busy=%b want %b valid=%b want %b beat=%h want %h err=%b want %b",
               name, gnt, eg, sel, es, busy, eb, out_valid, ev, beat, ebt, err, ee);
    end
  endtask

  initial begin
    logic [2:0] prev_sel;
    logic [2:0] ch;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req = 8'h00;
    lock = 8'h00;
    out_ready = 1'b0;

    // rst, req, lock, rdy -> gnt, sel, busy, valid, beat
    add(1'b0, 8'h01, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'h01, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'h01, 8'h00, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 8'h01);
    add(1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
    // All channels requesting: grants walk 1..7 then wrap to 0, one per 2 cycles
    prev_sel = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      ch = 3'(k % 8);
      add(1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, prev_sel, 1'b0, 1'b0, 8'h00);
      add(1'b1, 8'hFF, 8'h00, 1'b1, 8'h01 << ch, ch, 1'b1, 1'b1, 8'h01 << ch);
      prev_sel = ch;
    end
    // Locked burst on channel 3 capped at 4 beats; other req/lock activity ignored
    add(1'b1, 8'h08, 8'h08, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'h08, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1, 8'h08);
    add(1'b1, 8'hFF, 8'hFF, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1, 8'h08);
    add(1'b1, 8'hFF, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1, 8'h08);
    add(1'b1, 8'h08, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1, 8'h08);
    add(1'b1, 8'h18, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'h18, 8'h00, 1'b1, 8'h10, 3'd4, 1'b1, 1'b1, 8'h10);
    add(1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, 8'h00);
    // Lock dropped together with a beat: the beat counts, then release
    add(1'b1, 8'h08, 8'h08, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'h08, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1, 8'h08);
    add(1'b1, 8'h08, 8'h00, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1, 8'h08);
    add(1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 8'h00);
    // Channel 5 stalls, then withdraws while out_ready rises: no beat
    add(1'b1, 8'h20, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'h20, 8'h00, 1'b0, 8'h20, 3'd5, 1'b1, 1'b1, 8'h00);
    add(1'b1, 8'h00, 8'h00, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0, 8'h00);
    // Pointer now 6: next grants go 6, 7, then wrap to 0
    add(1'b1, 8'hC1, 8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'hC1, 8'h00, 1'b1, 8'h40, 3'd6, 1'b1, 1'b1, 8'h40);
    add(1'b1, 8'h81, 8'h00, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'h81, 8'h00, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 8'h80);
    add(1'b1, 8'h81, 8'h00, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'h81, 8'h00, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 8'h01);
    // Lock on non-granted channels only: single beat
    add(1'b1, 8'h02, 8'hFD, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'h02, 8'hFD, 1'b1, 8'h02, 3'd1, 1'b1, 1'b1, 8'h02);
    add(1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, 8'h00);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n     = tbl[i].rst_n;
      req       = tbl[i].req;
      lock      = tbl[i].lock;
      out_ready = tbl[i].rdy;
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].e_gnt, tbl[i].e_sel, tbl[i].e_busy,
                 tbl[i].e_valid, tbl[i].e_beat, 1'b0);
    end

    // Reset in the middle of a locked burst clears the grant asynchronously
    @(negedge clk);
    req = 8'h08; lock = 8'h08; out_ready = 1'b1;
    @(posedge clk); #1;
    check_outs("burst_start", 8'h08, 3'd3, 1'b1, 1'b1, 8'h08, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_outs("async_reset", 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; req = 8'h00; lock = 8'h00;
    @(posedge clk); #1;
    check_outs("post_reset_idle", 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Stalled grant on channel 2
    @(negedge clk);
    req = 8'h04; out_ready = 1'b0;
    @(posedge clk); #1;
    check_outs("stall_grant", 8'h04, 3'd2, 1'b1, 1'b1, 8'h00, 1'b0);
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
`ifdef MUX_ARB_TIMEOUT_EN
      if (c == 16) begin
        check_outs($sformatf("wdog_c%0d", c), 8'h00, 3'd2, 1'b0, 1'b0, 8'h00, 1'b1);
        n_vec++;
        if (dut.ptr_q !== 3'd3) begin
          n_bad++;
          $display("FAIL wdog_ptr: ptr=%0d want 3", dut.ptr_q);
        end
      end else begin
        check_outs($sformatf("wdog_c%0d", c), 8'h04, 3'd2, 1'b1, 1'b1, 8'h00, 1'b0);
      end
`else
      check_outs($sformatf("hold_c%0d", c), 8'h04, 3'd2, 1'b1, 1'b1, 8'h00, 1'b0);
`endif
    end
    @(negedge clk);
    req = 8'h00;
    @(posedge clk); #1;
    check_outs("stall_withdraw", 8'h00, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
